// File: rtl/trap_controller_pkg.sv
// Shared types and defaults for the trap entry/return controller.
package TrapPkg;

  // Controller states (the FSM table lives in trap_controller.sv).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_EXIT    = 2'd3
  } trap_state_e;

  localparam logic [31:0] HANDLER_BASE_DEFAULT = 32'h1c09_0000;
  localparam logic [31:0] HANDLER_LAST_DEFAULT = 32'h1c09_0088;
  localparam int          WDOG_CYCLES_DEFAULT  = 1024;

  // True when pc is a word-aligned address inside the inclusive ROM window.
  function automatic logic in_rom_window(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input logic [31:0] last);
    return (pc >= base) && (pc <= last) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/trap_controller_watchdog.sv
// Handler watchdog: down-counter loaded on clear, decremented while enabled,
// expire is high during an enabled cycle once the count has reached zero.
// Only instantiated when TRAP_WATCHDOG_EN is defined.
module TrapWatchdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] count;

  // Reload on clear, otherwise count down while enabled and not yet at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && (count == '0);

endmodule

// File: rtl/trap_controller.sv
// Trap entry/return controller: steers fetch into the exception-handler ROM on
// ecall and back to the saved PC on sret.
// Optional build macro: TRAP_WATCHDOG_EN adds a handler-residency watchdog that
// forces the return path and raises a sticky Timeout.
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_IDLE    | normal execution, waiting for an ecall
// ST_ENTER   | redirect to HANDLER_BASE held until fetch accepts
// ST_HANDLER | handler running, waiting for sret (or watchdog)
// ST_EXIT    | redirect to Sepc held until fetch accepts
module trap_controller
  import TrapPkg::*;
#(
  parameter logic [31:0] HANDLER_BASE = HANDLER_BASE_DEFAULT,
  parameter logic [31:0] HANDLER_LAST = HANDLER_LAST_DEFAULT,
  parameter int          WDOG_CYCLES  = WDOG_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EcallValid,
  input  logic [31:0] EcallPc,
  input  logic [31:0] EcallCode,
  input  logic        SretValid,
  input  logic [31:0] FetchPc,
  input  logic        RedirectReady,
  output logic        Redirect,
  output logic [31:0] RedirectPc,
  output logic        Flush,
  output logic        InHandler,
  output logic        RomSelect,
  output logic [31:0] Sepc,
  output logic [31:0] Scause,
  output logic        TrapError,
  output logic        Timeout
);

  // A watchdog shorter than two cycles would expire on the first handler cycle.
  if (WDOG_CYCLES < 2) begin : g_bad_wdog_cfg
    $error("trap_controller: WDOG_CYCLES must be at least 2");
  end

  trap_state_e state, state_next;
  logic        flush_next;
  logic        take_ecall;
  logic        err_set;
  logic        wdog_expire;

`ifdef TRAP_WATCHDOG_EN
  logic wdog_clear;
  logic wdog_enable;
  logic timeout_set;

  assign wdog_clear  = (state == ST_ENTER) && RedirectReady;
  assign wdog_enable = (state == ST_HANDLER);
  // An sret arriving in the expiry cycle wins; that is a normal return.
  assign timeout_set = wdog_expire && !SretValid;

  TrapWatchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (wdog_clear),
    .enable(wdog_enable),
    .expire(wdog_expire)
  );

  // Sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Timeout <= 1'b0;
    end else if (timeout_set) begin
      Timeout <= 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign Timeout     = 1'b0;
`endif

  // Next-state, flush request and protocol-error detection.
  always_comb begin
    state_next = state;
    flush_next = 1'b0;
    take_ecall = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (EcallValid) begin
          take_ecall = 1'b1;
          flush_next = 1'b1;
          state_next = ST_ENTER;
        end
        if (SretValid) begin
          err_set = 1'b1;
        end
      end
      ST_ENTER: begin
        if (RedirectReady) begin
          state_next = ST_HANDLER;
        end
        if (EcallValid) begin
          err_set = 1'b1;
        end
      end
      ST_HANDLER: begin
        if (SretValid || wdog_expire) begin
          flush_next = 1'b1;
          state_next = ST_EXIT;
        end
        if (EcallValid) begin
          err_set = 1'b1;
        end
      end
      ST_EXIT: begin
        if (RedirectReady) begin
          state_next = ST_IDLE;
        end
        if (EcallValid) begin
          err_set = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, registered flush pulse, trap context and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      Flush     <= 1'b0;
      Sepc      <= '0;
      Scause    <= '0;
      TrapError <= 1'b0;
    end else begin
      state <= state_next;
      Flush <= flush_next;
      if (take_ecall) begin
        Sepc   <= EcallPc + 32'd4;
        Scause <= EcallCode;
      end
      if (err_set) begin
        TrapError <= 1'b1;
      end
    end
  end

  // Redirect is a pure decode of the state register, so it holds until the
  // cycle fetch accepts it.
  assign Redirect   = (state == ST_ENTER) || (state == ST_EXIT);
  assign RedirectPc = (state == ST_EXIT) ? Sepc : HANDLER_BASE;
  assign InHandler  = (state != ST_IDLE);
  assign RomSelect  = in_rom_window(FetchPc, HANDLER_BASE, HANDLER_LAST);

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequential trap-entry/return controller for the pipelined core, driving the fetch unit into and out of the fixed exception-handler ROM at 0x1c090000. On an `ecall` retiring from EX it flushes the pipeline, saves the return PC and cause, and redirects fetch to the handler base. On the handler's terminating `sret` it redirects fetch back to the saved PC. It also tells the fetch mux when the current fetch PC lies inside the handler ROM window.

## Interface
Parameters:
- `HANDLER_BASE`, 32'h1c090000, first handler instruction address.
- `HANDLER_LAST`, 32'h1c090088, last handler instruction address (inclusive).
- `WDOG_CYCLES`, 1024, watchdog limit in cycles; used only when the watchdog is compiled in.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `EcallValid` in 1: EX-stage instruction is `ecall` (one-cycle qualifier).
- `EcallPc` in 32: PC of that `ecall`.
- `EcallCode` in 32: a7 value at the `ecall`.
- `SretValid` in 1: EX-stage instruction is `sret`.
- `FetchPc` in 32: current fetch address.
- `RedirectReady` in 1: fetch accepts the redirect this cycle.
- `Redirect` out 1: redirect request, held until accepted.
- `RedirectPc` out 32: redirect target.
- `Flush` out 1: kill IF/ID/EX; one-cycle pulse.
- `InHandler` out 1: handler active (state is not IDLE).
- `RomSelect` out 1: `FetchPc` is in [HANDLER_BASE, HANDLER_LAST] and word-aligned. Combinational.
- `Sepc` out 32: saved return PC.
- `Scause` out 32: captured `EcallCode`.
- `TrapError` out 1: sticky protocol-error flag.
- `Timeout` out 1: sticky watchdog flag (tied 0 when the watchdog is compiled out).

## Operation
- States:
  - IDLE: waits for `EcallValid`.
  - ENTER: drives the redirect to `HANDLER_BASE`.
  - HANDLER: waits for `SretValid`.
  - EXIT: drives the redirect to `Sepc`.
- IDLE + `EcallValid`:
  - `Sepc` <= `EcallPc` + 4, mod 2^32; 0xfffffffc wraps to 0.
  - `Scause` <= `EcallCode`.
  - `Flush` = 1 for one cycle.
  - Next state ENTER.
- ENTER: `Redirect` = 1, `RedirectPc` = `HANDLER_BASE`. On `RedirectReady`, go to HANDLER.
- HANDLER + `SretValid`: `Flush` pulse, next state EXIT.
- EXIT: `Redirect` = 1, `RedirectPc` = `Sepc`. On `RedirectReady`, go to IDLE.
- Errors (each sets sticky `TrapError`, which only reset clears):
  - `SretValid` in IDLE is ignored and sets `TrapError`.
  - `EcallValid` outside IDLE is ignored and sets `TrapError`. The handler is non-reentrant.
  - If `EcallValid` and `SretValid` are both high in HANDLER, `sret` is taken and `TrapError` is set.
- `Sepc` and `Scause` change only on an accepted `ecall`.

## Timing
- Reset (while `rst_n` = 0 at an edge), from any state including mid-redirect:
  - State goes to IDLE.
  - `Redirect`, `Flush`, `TrapError`, `Timeout` = 0.
  - `Sepc`, `Scause` = 0.
  - `RedirectPc` = `HANDLER_BASE`.
- `RedirectPc` is a don't-care when `Redirect` = 0.
- Entry latency:
  - `Flush` is registered and asserts in the cycle after `EcallValid` is sampled.
  - `Redirect` asserts in that same cycle; minimum one cycle when `RedirectReady` is already high.
- `Redirect` and `RedirectPc` stay stable until the cycle `RedirectReady` = 1 is sampled with `Redirect` = 1.
- Exit follows the same timing as entry.
- `RomSelect` is purely combinational, zero latency.

## Configuration
- `TRAP_WATCHDOG_EN` defined:
  - A cycle counter clears on entry to HANDLER and counts while in HANDLER.
  - When the count reaches `WDOG_CYCLES` - 1 without `sret`, the controller forces EXIT (`Flush` pulse, redirect to `Sepc`) and sets sticky `Timeout`.
- `TRAP_WATCHDOG_EN` undefined: no counter; `Timeout` is tied 0; HANDLER waits indefinitely.

## Structure
- Package `TrapPkg` holds:
  - the state enum (IDLE/ENTER/HANDLER/EXIT);
  - the `HANDLER_BASE` and `HANDLER_LAST` defaults;
  - the `WDOG_CYCLES` default.
- Sub-module `TrapWatchdog` (counter, clear, enable, expire pulse) is instantiated only under `TRAP_WATCHDOG_EN`.

## Test plan
- `ecall` at PC 0x00000100, a7 = 10: next cycle `Flush` = 1, `Redirect` = 1, `RedirectPc` = 0x1c090000; `Sepc` = 0x104, `Scause` = 10.
- `RedirectReady` held 0 for 3 cycles in ENTER: `Redirect`/`RedirectPc` stable for all 3 cycles; state reaches HANDLER only after `RedirectReady` = 1.
- In HANDLER, `SretValid`: `Flush` pulse, then `RedirectPc` = 0x104; after ready, back to IDLE with `InHandler` = 0.
- `ecall` at 0xfffffffc: `Sepc` = 0x00000000. `SretValid` in IDLE: no redirect, `TrapError` = 1 and sticky.
- `FetchPc` = 0x1c090088 gives `RomSelect` = 1; 0x1c09008c, 0x1c08fffc, and 0x1c090002 give `RomSelect` = 0. `rst_n` = 0 during EXIT clears all outputs to their reset values.
- With `TRAP_WATCHDOG_EN` and `WDOG_CYCLES` = 16: no `sret` for 16 cycles in HANDLER forces the redirect to `Sepc` and sets `Timeout` = 1.
